// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/alu_mc_if.sv
// Control-unit side handshake and operand/result bus of the multi-cycle ALU.
interface alu_mc_if #(parameter int W = 4);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] R;
  logic         zero;
  logic         carry;
  logic         sign;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (output start, op, A, B,
                  input  R, zero, carry, sign, ovf, busy, done);
  modport slave  (input  start, op, A, B,
                  output R, zero, carry, sign, ovf, busy, done);
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ADD/SUB/logic unit; SUB is A + ~B + 1 through the same adder.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         carry,
  output logic         ovf
);
  logic         is_sub;
  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    r      = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r     = sum[W-1:0];
        carry = sum[W];
        ovf   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_PASSB: r = b;
      default:  r = '0;  // MUL is handled by the sequencer
    endcase
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle ops via alu_comb, W-cycle shift-add multiply,
// result and flags registered behind a start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int CW = $clog2(W) + 1;

  state_t         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic           zero_q, zero_d, carry_q, carry_d, sign_q, sign_d, ovf_q, ovf_d;
  logic [W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d, acc_step;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     hi_sum;

  logic [W-1:0]   comb_r;
  logic           comb_c, comb_v;
  logic           commit;
  logic [W-1:0]   new_r;
  logic           new_c, new_v;

  alu_comb #(.W(W)) u_comb (
    .op    (bus.op),
    .a     (bus.A),
    .b     (bus.B),
    .r     (comb_r),
    .carry (comb_c),
    .ovf   (comb_v)
  );

  // One multiply step: conditionally add into the upper half, then shift the
  // whole accumulator right with the add's carry entering at the top.
  always_comb begin
    hi_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};
    acc_step = (2*W)'({hi_sum, acc_q[W-1:0]} >> 1);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    new_r    = '0;
    new_c    = 1'b0;
    new_v    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            commit  = 1'b1;
            new_r   = comb_r;
            new_c   = comb_c;
            new_v   = comb_v;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          commit  = 1'b1;
          new_r   = acc_step[W-1:0];
          new_c   = |acc_step[2*W-1:W];
          new_v   = |acc_step[2*W-1:W];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    r_d     = r_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    if (commit) begin
      r_d     = new_r;
      zero_d  = (new_r == '0);
      sign_d  = new_r[W-1];
      carry_d = new_c;
      ovf_d   = new_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.R     = r_q;
  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
  assign bus.sign  = sign_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == S_MUL);
  assign bus.done  = (state_q == S_DONE);
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at W=4 and W=8: transaction-level model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rst8 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.W(4)) if4 ();
  alu_mc_if #(.W(8)) if8 ();

  alu_mc #(.W(4)) u4 (.clk(clk), .reset(rst4), .bus(if4));
  alu_mc #(.W(8)) u8 (.clk(clk), .reset(rst8), .bus(if8));

  typedef struct packed {
    logic       vld;
    logic [7:0] r;
    logic       z, c, s, v, busy, done;
    logic [7:0] pr;
    logic       pc, pv;
    logic [4:0] rem;
  } m_t;

  m_t m4 = '0;
  m_t m8 = '0;

  // Result {r, carry, ovf} of one operation, straight from the arithmetic.
  function automatic logic [9:0] ref_op(int w, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    longint mask = (longint'(1) << w) - 1;
    longint aa = longint'(a) & mask;
    longint bb = longint'(b) & mask;
    longint bi = (~bb) & mask;
    longint s = 0;
    longint r = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      3'd0: begin s = aa + bb; r = s & mask; c = s[w];
        v = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]); end
      3'd1: begin s = aa + bi + 1; r = s & mask; c = s[w];
        v = (aa[w-1] == bi[w-1]) && (r[w-1] != aa[w-1]); end
      3'd2: r = aa & bb;
      3'd3: r = aa | bb;
      3'd4: r = aa ^ bb;
      3'd5: r = (~aa) & mask;
      3'd6: begin s = aa * bb; r = s & mask; c = ((s >> w) != 0); v = c; end
      default: r = bb;
    endcase
    return {r[7:0], c, v};
  endfunction

  function automatic m_t step(m_t m, int w, logic rst, logic st, logic [2:0] op,
                              logic [7:0] a, logic [7:0] b);
    m_t n = m;
    logic [9:0] res;
    if (!rst) begin
      n = '0;
      n.vld = 1'b1;
      return n;
    end
    if (!m.vld) return m;
    if (m.busy) begin
      n.rem = m.rem - 1;
      if (m.rem == 1) begin
        n.r = m.pr; n.c = m.pc; n.v = m.pv;
        n.z = (m.pr == 0); n.s = m.pr[w-1];
        n.busy = 1'b0; n.done = 1'b1;
      end
      return n;
    end
    n.done = 1'b0;
    if (st) begin
      res = ref_op(w, op, a, b);
      if (op == 3'd6) begin
        n.busy = 1'b1; n.rem = 5'(w);
        n.pr = res[9:2]; n.pc = res[1]; n.pv = res[0];
      end else begin
        n.r = res[9:2]; n.c = res[1]; n.v = res[0];
        n.z = (res[9:2] == 0); n.s = res[w+1];
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 <= step(m4, 4, rst4, if4.start, if4.op, {4'b0, if4.A}, {4'b0, if4.B});
    m8 <= step(m8, 8, rst8, if8.start, if8.op, if8.A, if8.B);
  end

  always @(negedge clk) begin
    logic [13:0] a4, e4, a8, e8;
    a4 = {4'b0, if4.R, if4.zero, if4.carry, if4.sign, if4.ovf, if4.busy, if4.done};
    e4 = {m4.r, m4.z, m4.c, m4.s, m4.v, m4.busy, m4.done};
    a8 = {if8.R, if8.zero, if8.carry, if8.sign, if8.ovf, if8.busy, if8.done};
    e8 = {m8.r, m8.z, m8.c, m8.s, m8.v, m8.busy, m8.done};
    if (m4.vld) begin
      checks++;
      if (a4 !== e4) begin
        failures++;
        $display("FAIL model_w4 t=%0t got {R,z,c,s,v,busy,done}=%h expected %h", $time, a4, e4);
      end
    end
    if (m8.vld) begin
      checks++;
      if (a8 !== e8) begin
        failures++;
        $display("FAIL model_w8 t=%0t got {R,z,c,s,v,busy,done}=%h expected %h", $time, a8, e8);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic go4(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    if4.start = 1'b1; if4.op = op; if4.A = a; if4.B = b;
  endtask

  // n = cycles since the accepting edge when done is seen; bc = busy cycles.
  task automatic wait_done(input bit big, output int n, output int bc);
    n = 1; bc = 0;
    while (!(big ? if8.done : if4.done) && n < 30) begin
      if (big ? if8.busy : if4.busy) bc++;
      tick();
      n++;
    end
  endtask

  logic [2:0] t_op [4] = '{3'd2, 3'd3, 3'd5, 3'd7};
  logic [3:0] t_a  [4] = '{4'hC, 4'hC, 4'h5, 4'h0};
  logic [3:0] t_b  [4] = '{4'hA, 4'h3, 4'h0, 4'h9};
  logic [3:0] t_r  [4] = '{4'h8, 4'hF, 4'hA, 4'h9};

  initial begin
    int n, bc;
    if4.start = 1'b0; if4.op = '0; if4.A = '0; if4.B = '0;
    if8.start = 1'b0; if8.op = '0; if8.A = '0; if8.B = '0;
    #1;
    tick(); tick();
    rst4 = 1'b1; rst8 = 1'b1;
    tick();
    chk("reset_w4", {if4.R, if4.zero, if4.carry, if4.sign, if4.ovf, if4.busy, if4.done}, 16'h0);

    go4(3'd0, 4'b0111, 4'b0001); tick();
    chk("add_flags", {if4.R, if4.zero, if4.carry, if4.sign, if4.ovf, if4.busy, if4.done},
        {4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});

    go4(3'd1, 4'b0011, 4'b0011); tick();
    chk("sub_zero", {if4.R, if4.zero, if4.carry, if4.ovf, if4.done}, {4'b0000, 1'b1, 1'b1, 1'b0, 1'b1});
    go4(3'd1, 4'b0000, 4'b0001); tick();
    chk("sub_borrow", {if4.R, if4.carry, if4.sign, if4.done}, {4'b1111, 1'b0, 1'b1, 1'b1});

    for (int i = 0; i < 4; i++) begin
      go4(t_op[i], t_a[i], t_b[i]); tick();
      chk("logic_op", {if4.R, if4.carry, if4.ovf, if4.done}, {t_r[i], 1'b0, 1'b0, 1'b1});
    end
    if4.start = 1'b0; tick();

    go4(3'd6, 4'b0101, 4'b0011); tick();
    if4.start = 1'b0;
    wait_done(1'b0, n, bc);
    chk("mul5x3_latency", 16'(n), 16'd5);
    chk("mul5x3_busy", 16'(bc), 16'd4);
    chk("mul5x3_res", {if4.R, if4.carry, if4.ovf}, {4'b1111, 1'b0, 1'b0});

    go4(3'd6, 4'b1111, 4'b1111); tick();
    if4.start = 1'b0; tick();
    go4(3'd4, 4'b1010, 4'b0110); tick();
    if4.start = 1'b0;
    chk("held_mid_mul", {if4.R, if4.busy}, {4'b1111, 1'b1});
    wait_done(1'b0, n, bc);
    chk("mul15x15", {if4.R, if4.carry, if4.ovf, if4.done}, {4'b0001, 1'b1, 1'b1, 1'b1});

    go4(3'd4, 4'b1010, 4'b0110); tick();
    if4.start = 1'b0;
    chk("xor_from_done", {if4.R, if4.carry, if4.ovf, if4.busy, if4.done},
        {4'b1100, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    chk("done_one_cycle", {15'b0, if4.done}, 16'h0);

    if8.start = 1'b1; if8.op = 3'd6; if8.A = 8'd200; if8.B = 8'd2; tick();
    if8.start = 1'b0; tick(); tick();
    chk("mul8_busy3", {15'b0, if8.busy}, 16'h1);
    rst8 = 1'b0; tick();
    rst8 = 1'b1;
    chk("abort_reset", {if8.R, if8.zero, if8.carry, if8.sign, if8.ovf, if8.busy, if8.done}, 16'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_done_after_abort", {15'b0, if8.done}, 16'h0);
    end

    if8.start = 1'b1; if8.op = 3'd6; if8.A = 8'd12; if8.B = 8'd11; tick();
    if8.start = 1'b0;
    wait_done(1'b1, n, bc);
    chk("mul12x11_latency", 16'(n), 16'd9);
    chk("mul12x11_res", {if8.R, if8.sign, if8.carry, if8.zero}, {8'h84, 1'b1, 1'b0, 1'b0});
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: successor to the 4-bit combinational ALU with zero/carry/sign flags. It extends that ALU to W bits, adds XOR, NOT, pass-B and an iterative unsigned shift-add multiply, and registers the result and flags behind a start/busy/done handshake. It sits between the datapath register file and the flag register. The control unit issues one operation and waits for `done` before using `R` or the flags.

## Interface
- `W`, default 4: operand/result width, ≥2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising `clk`.
- `start` input 1: request; sampled only while `busy`=0.
- `op` input 3: operation code, captured with `start`.
- `A`, `B` input W: operands, captured with `start`.
- `R` output W: registered result.
- `zero`, `carry`, `sign`, `ovf` output 1 each: registered flags.
- `busy` output 1: operation in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse; `R` and the flags are valid from this cycle on.

## Operation
- Op codes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 MUL: unsigned; low W bits to `R`.
  - 111 PASS B.
- Flags:
  - `zero` = (R==0).
  - `sign` = R[W-1].
  - ADD: `carry` = carry-out of bit W-1.
  - SUB: `carry` = carry-out of A+~B+1, so 1 means no borrow.
  - ADD/SUB: `ovf` = two's-complement overflow, i.e. operands' signs agree (after B inversion for SUB) and `sign` differs.
  - Logic ops and PASS B: `carry`=0, `ovf`=0.
  - MUL: `carry` = `ovf` = (upper W bits of the 2W product ≠ 0).
- `R` and all flags update only at completion. They hold their value otherwise, including while a MUL is running.
- FSM states:
  - IDLE: `busy`=0. On `start`=1 with a non-MUL op, compute, write `R`/flags and go to DONE. On `start`=1 with `op`=110, load the multiplicand, multiplier and a 2W-bit accumulator=0, set counter=0, go to MUL.
  - MUL: `busy`=1. Each cycle: if multiplier LSB=1, add multiplicand at the upper half of the accumulator; shift the accumulator and multiplier right by 1; counter+1. When counter reaches W-1 on the current edge, write `R`/flags from the final accumulator and go to DONE.
  - DONE: `done`=1, `busy`=0. A `start` here is accepted exactly as in IDLE, so back-to-back operations are allowed. Return to IDLE if there is no `start`.
- Unknown states recover to IDLE.
- `start` while `busy`=1 is dropped. It is not queued.
- `reset`=0 at any point, including mid-MUL, gives the following on the next edge: state IDLE, `R`=0, all flags 0, `busy`=0, `done`=0, counter 0, no `done` for the aborted op.
- Counter width: clog2(W)+1.

## Timing
- Edge k samples `start`.
- Non-MUL op: `R`/flags valid and `done`=1 in the cycle after edge k. Latency 1.
- MUL: `busy`=1 for cycles after edges k … k+W-1. Result written at edge k+W. `done`=1 in the cycle after edge k+W. Latency W+1.
- Throughput:
  - Non-MUL ops: one op per cycle when `start` is held in DONE.
  - MUL: one per W+1 cycles.
- `done` never lasts more than one cycle per accepted `start`. `busy` and `done` are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg` holds:
  - Op-code localparams: OP_ADD … OP_PASSB.
  - FSM state encoding: S_IDLE, S_MUL, S_DONE.
- One sub-module `alu_comb`: the parametrised combinational ADD/SUB/logic unit with W-bit result plus carry/ovf, using the complement-to-one plus carry-in scheme.
- The FSM, the shift-add multiplier and the flag registers live in `alu_mc`.

## Test plan
- W=4, reset low for 2 cycles, then release → `R`=0, all flags 0, `busy`=0, `done`=0.
- W=4, ADD A=0111 B=0001 → `done` after 1 cycle; R=1000, sign=1, ovf=1, carry=0, zero=0.
- W=4, SUB A=0011 B=0011 → R=0000, zero=1, carry=1, ovf=0. Then SUB A=0000 B=0001 → R=1111, carry=0, sign=1.
- W=4, MUL A=0101 B=0011 → `busy` high 4 cycles; `done` at cycle 5; R=1111, carry=0. Then MUL A=1111 B=1111 → R=0001, carry=ovf=1.
- W=4, `start`/XOR issued mid-MUL → ignored; MUL result unchanged. XOR A=1010 B=0110 then issued from DONE on the very next edge → R=1100, carry=0, ovf=0, `done` on the following cycle.
- W=8, MUL 200×2 with reset low asserted on the 3rd busy cycle → next cycle all outputs 0, no `done`. A subsequent MUL 12×11 → R=132 (0x84), sign=1, carry=0, `done` 9 cycles after `start`.
